seven_seg_reader: RTL and testbench
===================================

SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples needed to accept a digit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port seg_in, input, 7, meaning an active-low segment pattern, bit0=a … bit6=g.
REQ-005 SHALL have port digit_sel, input, 4, meaning a one-hot strobe naming the scanned digit (bit3 = most significant nibble).
REQ-006 SHALL have port out_value, output, 16, meaning the decoded 4-digit frame, digit3 in bits [15:12].
REQ-007 SHALL have port out_err, output, 4, meaning a per-digit flag set when the captured pattern was not a legal glyph.
REQ-008 SHALL have port out_valid, output, 1, meaning out_value/out_err hold a complete frame.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the frame.
REQ-010 SHALL have port overflow, output, 1, meaning a sticky flag that a frame was dropped.

Function
REQ-011 SHALL register seg_in and digit_sel once (sample stage) before any comparison; all timing below counts from the sampled values.
REQ-012 SHALL decode the 16 legal glyphs (hex, g..a) 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-013 SHALL map any other pattern to nibble 0 with the digit's err bit set.
REQ-014 SHALL count consecutive cycles where the sampled (digit_sel, seg_in) pair equals the previous sample and digit_sel is one-hot; the counter restarts at 1 on any change and holds 0 for a non-one-hot select (including 0000).
REQ-015 SHALL capture the digit into its slot and set its slot_done bit on the cycle the counter reaches STABLE_CYCLES, exactly once per dwell; the counter saturates thereafter.
REQ-016 SHALL let a recapture of an already-done slot within a frame overwrite that slot (latest wins).
REQ-017 SHALL, on the cycle after slot_done becomes 1111 with out_valid low, load out_value/out_err, assert out_valid and clear slot_done.
REQ-018 SHALL, when a frame completes while out_valid is high and out_ready is low, discard the new frame, keep the held output unchanged, set overflow and clear slot_done.
REQ-019 SHALL deassert out_valid on the cycle after out_valid && out_ready, unless a frame completes in that same cycle, in which case it SHALL load the new frame and keep out_valid high.
REQ-020 SHALL hold out_value/out_err stable while out_valid is high; overflow SHALL clear only on reset.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear the sample registers, counter, slots, slot_done, out_value=0, out_err=0, out_valid=0, overflow=0.
REQ-022 SHALL discard any partial frame when reset is asserted mid-frame; capture SHALL restart from an empty frame after release.

Structure
REQ-023 SHALL place the 16 glyph constants and the frame width constant in the shared package seven_seg_pkg.
REQ-024 SHALL implement glyph-to-nibble lookup in a combinational sub-module seg_glyph_decode (7-bit in; 4-bit nibble and err out).

Verification
REQ-025 SHALL cover: scan digits 3..0 = 0001000,0110000,0000000,0100001 for 4 cycles each, out_ready=1 -> out_valid=1 with out_value=16'hA38D, out_err=0.
REQ-026 SHALL cover: digit 2 dwells 3 cycles only (STABLE_CYCLES=4) -> no capture for digit 2, no frame until it dwells 4 cycles.
REQ-027 SHALL cover: digit 1 pattern 1111111 -> out_err=4'b0010, nibble 1 = 0.
REQ-028 SHALL cover: two complete frames, out_ready=0 -> first frame held, overflow=1; then out_ready=1 -> out_valid drops the next cycle.
REQ-029 SHALL cover: digit_sel=0101 or 0000 held 10 cycles -> no capture; rst_n pulse after 3 digits -> outputs 0, next frame requires all 4 digits.
REQ-030 SHALL cover: frame completion in the same cycle as a handshake -> new value loaded, out_valid stays 1.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan reader.
//   FRAME_W    : width of the decoded 4-digit frame
//   NUM_DIGITS : digits per frame (one per digit_sel bit)
//   GLYPH_0..F : active-low segment patterns, bit6=g .. bit0=a
package seven_seg_pkg;

    localparam int unsigned FRAME_W    = 16;
    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0011000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-to-nibble lookup.
//   i_seg    : active-low segment pattern (bit0=a .. bit6=g)
//   o_nibble : hex value of the glyph, 0 for an unknown pattern
//   o_err    : high when i_seg is not one of the 16 legal glyphs
module seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_err
);

    always_comb begin
        o_nibble = '0;
        o_err    = 1'b1;
        case (i_seg)
            GLYPH_0: begin o_nibble = 4'h0; o_err = 1'b0; end
            GLYPH_1: begin o_nibble = 4'h1; o_err = 1'b0; end
            GLYPH_2: begin o_nibble = 4'h2; o_err = 1'b0; end
            GLYPH_3: begin o_nibble = 4'h3; o_err = 1'b0; end
            GLYPH_4: begin o_nibble = 4'h4; o_err = 1'b0; end
            GLYPH_5: begin o_nibble = 4'h5; o_err = 1'b0; end
            GLYPH_6: begin o_nibble = 4'h6; o_err = 1'b0; end
            GLYPH_7: begin o_nibble = 4'h7; o_err = 1'b0; end
            GLYPH_8: begin o_nibble = 4'h8; o_err = 1'b0; end
            GLYPH_9: begin o_nibble = 4'h9; o_err = 1'b0; end
            GLYPH_A: begin o_nibble = 4'hA; o_err = 1'b0; end
            GLYPH_B: begin o_nibble = 4'hB; o_err = 1'b0; end
            GLYPH_C: begin o_nibble = 4'hC; o_err = 1'b0; end
            GLYPH_D: begin o_nibble = 4'hD; o_err = 1'b0; end
            GLYPH_E: begin o_nibble = 4'hE; o_err = 1'b0; end
            GLYPH_F: begin o_nibble = 4'hF; o_err = 1'b0; end
            default: begin o_nibble = '0;   o_err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Reads a multiplexed 4-digit seven-segment display and emits decoded frames.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   seg_in      : active-low segment pattern of the digit currently lit
//   digit_sel   : one-hot strobe naming that digit (bit3 = most significant)
//   out_value   : decoded frame, digit3 in [15:12]
//   out_err     : per-digit flag, captured pattern was not a legal glyph
//   out_valid   : out_value/out_err hold a complete frame
//   out_ready   : consumer accepts the held frame
//   overflow    : sticky, a completed frame was dropped while output was held
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_in,
    input  logic [3:0]           digit_sel,
    output logic [FRAME_W-1:0]   out_value,
    output logic [3:0]           out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    logic [6:0]         r_seg;
    logic [3:0]         r_sel;
    logic [6:0]         r_prev_seg;
    logic [3:0]         r_prev_sel;
    logic [7:0]         r_cnt;
    logic [FRAME_W-1:0] r_slot_val;
    logic [3:0]         r_slot_err;
    logic [3:0]         r_slot_done;
    logic [FRAME_W-1:0] r_out_value;
    logic [3:0]         r_out_err;
    logic               r_out_valid;
    logic               r_overflow;

    logic [3:0] w_nibble;
    logic       w_glyph_err;
    logic [7:0] w_cnt_next;
    logic       w_capture;
    logic       w_frame_done;
    logic       w_load;
    logic       w_drop;
    logic [3:0] w_done_next;

    seg_glyph_decode u_decode (
        .i_seg    (r_seg),
        .o_nibble (w_nibble),
        .o_err    (w_glyph_err)
    );

    always_comb begin
        w_cnt_next = '0;
        if ($onehot(r_sel)) begin
            if (r_sel == r_prev_sel && r_seg == r_prev_seg) begin
                w_cnt_next = (r_cnt == STABLE_C) ? r_cnt : r_cnt + 8'd1;
            end else begin
                w_cnt_next = 8'd1;
            end
        end
        // Fires only on the transition into STABLE_C, so a long dwell
        // captures exactly once while the counter sits saturated.
        w_capture    = (w_cnt_next == STABLE_C) && (r_cnt != STABLE_C);
        w_frame_done = (r_slot_done == 4'hF);
        w_load       = w_frame_done && (!r_out_valid || out_ready);
        w_drop       = w_frame_done && r_out_valid && !out_ready;
        w_done_next  = (w_frame_done ? 4'h0 : r_slot_done) | (w_capture ? r_sel : 4'h0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg       <= '0;
            r_sel       <= '0;
            r_prev_seg  <= '0;
            r_prev_sel  <= '0;
            r_cnt       <= '0;
            r_slot_val  <= '0;
            r_slot_err  <= '0;
            r_slot_done <= '0;
            r_out_value <= '0;
            r_out_err   <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_seg       <= seg_in;
            r_sel       <= digit_sel;
            r_prev_seg  <= r_seg;
            r_prev_sel  <= r_sel;
            r_cnt       <= w_cnt_next;
            r_slot_done <= w_done_next;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && r_sel[i]) begin
                    r_slot_val[i*4 +: 4] <= w_nibble;
                    r_slot_err[i]        <= w_glyph_err;
                end
            end
            if (w_load) begin
                r_out_value <= r_slot_val;
                r_out_err   <= r_slot_err;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_value = r_out_value;
    assign out_err   = r_out_err;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: directed scenarios with literal
// expectations plus randomized scanning, all checked every cycle against a
// behavioural model of the reader.
module tb_seven_seg_reader;

    localparam int unsigned S = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  digit_sel = 4'h0;
    logic        out_ready = 1'b1;
    logic [15:0] out_value;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        overflow;

    always #5 clk = ~clk;

    seven_seg_reader #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .digit_sel (digit_sel),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [4:0] ref_decode(input logic [6:0] pat);
        for (int g = 0; g < 16; g++) begin
            if (GLYPH[g] == pat) return {1'b0, 4'(g)};
        end
        return 5'b1_0000;
    endfunction

    logic [15:0] m_out_val;
    logic [3:0]  m_out_err;
    logic        m_valid;
    logic        m_ovf;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_gerr;
    logic [3:0]  m_done;
    logic [3:0]  st_sel;
    logic [6:0]  st_seg;
    int          st_run;
    int          run_new;
    int          slot;
    logic [4:0]  dec;

    // st_* is the sample registered one edge ago, with the length of the run
    // of identical samples it ends. A digit is taken when that run is
    // exactly S long; the frame moves to the output one edge later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out_val = '0;
            m_out_err = '0;
            m_valid   = 1'b0;
            m_ovf     = 1'b0;
            m_gerr    = '0;
            m_done    = '0;
            for (int b = 0; b < 4; b++) m_nib[b] = '0;
            st_sel = '0;
            st_seg = '0;
            st_run = 0;
        end else begin
            if (m_done == 4'hF) begin
                m_done = 4'h0;
                if (!m_valid || out_ready) begin
                    m_out_val = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    m_out_err = m_gerr;
                    m_valid   = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if ($countones(st_sel) == 1 && st_run == S) begin
                slot = 0;
                for (int b = 0; b < 4; b++) if (st_sel[b]) slot = b;
                dec = ref_decode(st_seg);
                m_nib[slot]  = dec[3:0];
                m_gerr[slot] = dec[4];
                m_done[slot] = 1'b1;
            end
            run_new = (digit_sel == st_sel && seg_in == st_seg) ? st_run + 1 : 1;
            st_sel  = digit_sel;
            st_seg  = seg_in;
            st_run  = run_new;
        end
    end

    always @(negedge clk) begin
        check("value", out_value, m_out_val);
        check("err",   16'(out_err), 16'(m_out_err));
        check("valid", 16'(out_valid), 16'(m_valid));
        check("ovf",   16'(overflow), 16'(m_ovf));
    end

    // ---------------- stimulus ----------------
    task automatic show(input logic [3:0] sel, input logic [6:0] seg, input int n);
        digit_sel = sel;
        seg_in    = seg;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        show(4'b0000, 7'h7F, n);
    endtask

    task automatic frame4(input logic [6:0] g3, input logic [6:0] g2,
                          input logic [6:0] g1, input logic [6:0] g0);
        show(4'b1000, g3, S);
        show(4'b0100, g2, S);
        show(4'b0010, g1, S);
        show(4'b0001, g0, S);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check(name, 16'(out_valid), 16'h1);
        @(posedge clk);
        #2;
    endtask

    logic [3:0] r_sel;
    logic [6:0] r_seg;

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_value", out_value, 16'h0000);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_ovf", 16'(overflow), 16'h0);
        rst_n = 1'b1;
        idle(2);

        // A 3 8 d, consumer ready
        frame4(GLYPH[10], GLYPH[3], GLYPH[8], GLYPH[13]);
        idle(1);
        for (int i = 0; i < 12; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check("s1_valid", 16'(out_valid), 16'h1);
        check("s1_value", out_value, 16'hA38D);
        check("s1_err", 16'(out_err), 16'h0);
        @(posedge clk);
        #2;
        check("s1_drop", 16'(out_valid), 16'h0);
        idle(3);

        // digit 2 dwells only S-1 cycles
        show(4'b1000, GLYPH[1], S);
        show(4'b0100, GLYPH[7], S - 1);
        show(4'b0010, GLYPH[5], S);
        show(4'b0001, GLYPH[15], S);
        idle(6);
        check("s2_nocap", 16'(out_valid), 16'h0);
        show(4'b0100, GLYPH[2], S);
        wait_valid("s2_valid");
        check("s2_value", out_value, 16'h125F);
        idle(3);

        // illegal pattern on digit 1
        frame4(GLYPH[14], GLYPH[6], 7'b1111111, GLYPH[9]);
        wait_valid("s3_valid");
        check("s3_value", out_value, 16'hE609);
        check("s3_err", 16'(out_err), 16'h2);
        idle(3);

        // back-pressure: second frame dropped
        out_ready = 1'b0;
        frame4(GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4]);
        wait_valid("s4_valid");
        check("s4_value", out_value, 16'h1234);
        frame4(GLYPH[5], GLYPH[6], GLYPH[7], GLYPH[8]);
        idle(4);
        check("s4_hold", out_value, 16'h1234);
        check("s4_ovf", 16'(overflow), 16'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check("s4_drop", 16'(out_valid), 16'h0);

        // non-one-hot selects, then reset mid-frame
        show(4'b0101, GLYPH[8], 10);
        show(4'b0000, GLYPH[8], 10);
        check("s5_nocap", 16'(out_valid), 16'h0);
        check("s5_sticky", 16'(overflow), 16'h1);
        show(4'b0100, GLYPH[1], S);
        show(4'b0010, GLYPH[2], S);
        show(4'b0001, GLYPH[3], S);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check("s5_rst_value", out_value, 16'h0000);
        check("s5_rst_ovf", 16'(overflow), 16'h0);
        rst_n = 1'b1;
        show(4'b1000, GLYPH[12], S);
        idle(6);
        check("s5_partial", 16'(out_valid), 16'h0);
        show(4'b0100, GLYPH[0], S);
        show(4'b0010, GLYPH[15], S);
        show(4'b0001, GLYPH[14], S);
        wait_valid("s5_valid");
        check("s5_value", out_value, 16'hC0FE);
        idle(3);

        // frame completes on the handshake edge
        out_ready = 1'b0;
        frame4(GLYPH[9], GLYPH[8], GLYPH[7], GLYPH[6]);
        wait_valid("s6_first");
        check("s6_first_value", out_value, 16'h9876);
        frame4(GLYPH[10], GLYPH[11], GLYPH[12], GLYPH[13]);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        check("s6_valid", 16'(out_valid), 16'h1);
        check("s6_value", out_value, 16'hABCD);
        check("s6_ovf", 16'(overflow), 16'h0);
        out_ready = 1'b1;
        idle(3);

        // randomized scanning
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 8) r_sel = 4'(1 << $urandom_range(0, 3));
            else r_sel = 4'($urandom);
            if ($urandom_range(0, 5) != 0) r_seg = GLYPH[$urandom_range(0, 15)];
            else r_seg = 7'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (it == 150) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
            show(r_sel, r_seg, int'($urandom_range(1, 7)));
        end
        out_ready = 1'b1;
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
